// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants for the 8-digit hex 7-segment scanner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs; element [n] is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Combinational nibble to active-low 7-segment glyph decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

`default_nettype wire

// File: rtl/sysout_seg7_scan.sv
// ============================================================================
// Module   : sysout_seg7_scan
// Purpose  : Captures the CPU sysout word and time-multiplexes it onto an
//            8-digit common-anode display with leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sysout_seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  dp_flag,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend;
  logic [31:0]      r_shown;
  logic             r_pend_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_armed;
  logic             r_blank;
  logic             r_dpf;
  logic             r_upd;

  logic             w_tick;
  logic [31:0]      w_upper;
  logic             w_blank_dig;
  logic [6:0]       w_glyph;

  assign w_tick = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_shown      <= '0;
      r_idx        <= '0;
      r_armed      <= 1'b0;
      r_blank      <= 1'b0;
      r_dpf        <= 1'b1;
      r_upd        <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_upd <= w_tick;
      if (w_tick) begin
        // The old pending word commits now; a same-cycle load waits for the next tick.
        if (r_pend_valid) begin
          r_shown      <= r_pend;
          r_pend_valid <= 1'b0;
        end
        if (r_armed) r_idx <= r_idx + 1'b1;
        else         r_armed <= 1'b1;
        r_blank <= blank_lz;
        r_dpf   <= dp_flag;
      end
      if (load) begin
        r_pend       <= data_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Nibbles at and above the active digit; zero means this digit is a leading zero.
  assign w_upper     = r_shown >> {r_idx, 2'b00};
  assign w_blank_dig = r_blank && (r_idx != '0) && (w_upper == 32'd0);

  hex_to_seg7 u_hex (
    .nibble (w_upper[3:0]),
    .seg    (w_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (r_upd) begin
      an  <= w_blank_dig ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      seg <= w_blank_dig ? SEG_BLANK : w_glyph;
      dp  <= !((r_idx == '0) && !r_dpf);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysout_seg7_scan.sv
// ============================================================================
// Module   : tb_sysout_seg7_scan
// Purpose  : Self-checking bench for sysout_seg7_scan with a timeline model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sysout_seg7_scan;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        dp_flag = 1'b1;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sysout_seg7_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_flag  (dp_flag),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Timeline model: n counts clock edges since reset release; ticks land on
  // edges where n is a multiple of CLK_DIV, outputs follow one edge later.
  int          n;
  logic [31:0] m_pend, m_shown;
  bit          m_pv, m_armed, m_blank, m_dpf, m_upd;
  int          m_digit;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic model_reset();
    n = 0; m_pend = '0; m_shown = '0; m_pv = 0; m_armed = 0;
    m_blank = 0; m_dpf = 1; m_upd = 0; m_digit = 0;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
  endtask

  task automatic model_edge();
    logic [31:0] up;
    n++;
    if (m_upd) begin
      up = m_shown >> (4 * m_digit);
      if (m_blank && m_digit != 0 && up == 32'd0) begin
        e_an = 8'hFF; e_seg = 7'h7F;
      end else begin
        e_an = ~(8'h01 << m_digit); e_seg = glyph[up[3:0]];
      end
      e_dp = (m_digit == 0 && !m_dpf) ? 1'b0 : 1'b1;
      m_upd = 0;
    end
    if (n % CLK_DIV == 0) begin
      if (m_pv) begin m_shown = m_pend; m_pv = 0; end
      if (m_armed) m_digit = (m_digit + 1) % 8;
      else         m_armed = 1;
      m_blank = blank_lz; m_dpf = dp_flag; m_upd = 1;
    end
    if (load) begin m_pend = data_in; m_pv = 1; end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("an",  {24'd0, an},  {24'd0, e_an});
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("dp",  {31'd0, dp},  {31'd0, e_dp});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    chk_outputs();
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic do_load(logic [31:0] v);
    data_in = v; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  int seen_11;

  initial begin
    // Synchronous-looking reset pulse, then the first-digit latency.
    @(negedge clk);
    rst = 1'b1; model_reset();
    run(3);
    rst = 1'b0;
    run(4);
    chk("rst_an_c4", {24'd0, an}, 32'h0000_00FF);
    cyc();
    chk("first_an_c5",  {24'd0, an},  32'h0000_00FE);
    chk("first_seg_c5", {25'd0, seg}, 32'h0000_0040);

    // Full walk with wrap, decimal point on digit 0.
    blank_lz = 1'b0; dp_flag = 1'b0;
    do_load(32'h1234_5678);
    run(80);

    // Leading-zero blanking, then value zero.
    dp_flag = 1'b1; blank_lz = 1'b1;
    do_load(32'h0000_00A0);
    run(40);
    do_load(32'h0000_0000);
    run(40);

    // Two loads inside one slot: only the later one may be displayed.
    blank_lz = 1'b0;
    for (int k = 0; k < 8 && (n % CLK_DIV) != 1; k++) cyc();
    do_load(32'h1111_1111);
    do_load(32'h2222_2222);
    seen_11 = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (seg == 7'h79) seen_11++;
    end
    chk("never_shows_11111111", seen_11, 0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        data_in = $urandom >> $urandom_range(0, 31);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) blank_lz = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) dp_flag  = $urandom_range(0, 1);
      cyc();
    end
    load = 1'b0;

    // Asynchronous reset in the middle of a scan with a pending word.
    blank_lz = 1'b0; dp_flag = 1'b0;
    for (int k = 0; k < 64 && !(m_digit == 5 && m_upd == 0); k++) cyc();
    do_load(32'hDEAD_BEEF);
    #1 rst = 1'b1; model_reset();
    #1;
    chk("async_an",  {24'd0, an},  32'h0000_00FF);
    chk("async_seg", {25'd0, seg}, 32'h0000_007F);
    chk("async_dp",  {31'd0, dp},  32'h0000_0001);
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(4);
    chk("rerst_an_c4", {24'd0, an}, 32'h0000_00FF);
    cyc();
    chk("rerst_an_c5",  {24'd0, an},  32'h0000_00FE);
    chk("rerst_seg_c5", {25'd0, seg}, 32'h0000_0040);
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sysout_seg7_scan.md
Name: sysout_seg7_scan

Overview:
- Consumer end of the syscall-output path: takes the 32-bit value the CPU publishes on sysout, plus the notEqual flag, and shows it on the board's 8-digit common-anode 7-segment display.
- Holds a pending/committed value pair so the display only changes at digit boundaries.
- Time-multiplexes the 8 hex digits with a prescaled scan counter.
- Optionally blanks leading zeros; drives the decimal point from the flag.

Parameters:
- CLK_DIV, 100000, clk cycles per digit slot; legal range 2..2^20; benches use 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- data_in  input  32  value to display (sysout)
- load  input  1  capture strobe; data_in sampled when high
- blank_lz  input  1  1 = blank leading-zero digits
- dp_flag  input  1  notEqual; decimal point of digit 0 lit when 0
- an  output  8  digit enables, active-low, an[i] = digit i (digit 0 = least significant nibble)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Asserting rst forces, immediately: an=8'hFF, seg=7'h7F, dp=1, pending=0, pend_valid=0, shown=0, prescaler=0, digit index=0, armed=0.
- Capture:
  - Clock edge with load=1: pending <= data_in, pend_valid <= 1.
  - Loads in consecutive cycles: last one wins. No backpressure; load is never refused.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (count == CLK_DIV-1).
- On a tick:
  - If pend_valid: shown <= pending, pend_valid <= 0.
  - If load=1 in the same tick cycle, the new data_in goes to pending, pend_valid stays 1, and it commits on the next tick. The old pending value is committed now.
  - Digit index: if armed=0, set armed <= 1 and keep index=0. Otherwise index <= (index+1) mod 8, wrapping 7 -> 0.
  - Outputs registered: an/seg/dp take their new values on the edge after the tick, computed from the post-tick index and shown.
- First output after reset:
  - With CLK_DIV=4, tick occurs at cycles 3, 7, 11, ...
  - an stays 8'hFF through cycle 4.
  - an=8'hFE first appears at cycle 5 and holds exactly CLK_DIV cycles.
- Digit content:
  - nibble = shown[4*i+3 : 4*i], decoded to the standard hex glyph, active-low.
  - Glyph table: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Blanking:
  - Digit i (i >= 1) is blanked when blank_lz=1 and nibbles i..7 are all zero.
  - Blanked digit: its an bit stays 1; seg=7'h7F.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_lz is sampled at the tick, per digit slot.
- Decimal point:
  - dp=0 only while digit 0 is active and dp_flag=0; otherwise dp=1.
  - dp_flag is sampled at the tick.
- an: exactly one bit low at a time, or none (blanked digit, or before arming).
- Glitch-free: an/seg/dp change only on the edge following a tick.

Decomposition:
- Package seg7_pkg: NUM_DIGITS=8, SEG_BLANK=7'h7F, the 16-entry hex glyph constant table, and the digit-index width (3).
- Sub-module hex_to_seg7: combinational 4-bit nibble -> 7-bit active-low glyph via the package table. Instantiated once on the muxed nibble.
- The top holds the capture, prescaler, scan and output registers.

Test Plan (CLK_DIV=4):
- Reset: assert rst for 3 cycles, release -> an=FF, seg=7F, dp=1 through cycle 4; an=FE at cycle 5 with seg=0x40.
- load 0x12345678, blank_lz=0 -> after the commit tick, digit0 seg=0x00 ("8"), digit7 seg=0x79 ("1"); an walks FE, FD, ... 7F, then back to FE (wrap 7 -> 0 checked).
- load 0x000000A0, blank_lz=1 -> digit0 seg=0x40, digit1 seg=0x08, digits 2..7 an=FF, seg=7F. Then load 0 -> only digit 0 lit, shows "0".
- Mid-slot updates: load 0x11111111 two cycles before a tick, load 0x22222222 the next cycle -> the old value stays displayed until the tick, then all digits show 0x24; 0x11111111 is never displayed.
- dp_flag=0 -> dp=0 only during the digit-0 slot. dp_flag=1 -> dp=1 always.
- Async reset mid-scan (index 5, pending valid) -> outputs return to reset values in the same cycle without a clock edge; pending is discarded; the scan restarts as in the reset scenario.
